// File: rtl/snn_pkg.sv
// rtl/snn_pkg.sv - shared types and defaults for the spike rate decoder (optional trace: SPIKE_TRACE_EN)
package snn_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    HOLD  = 2'd2
  } dec_state_t;

  localparam int DEC_NUM_CH_DEF  = 2;
  localparam int DEC_CNT_W_DEF   = 8;
  localparam int DEC_WIN_W_DEF   = 8;
  localparam int TRACE_SHIFT_DEF = 2;

endpackage

// File: rtl/spike_counter_sat.sv
// rtl/spike_counter_sat.sv - one channel: saturating spike counter with sticky sat (leaky trace under SPIKE_TRACE_EN)
module spike_counter_sat
  import snn_pkg::*;
#(
  parameter int CNT_W = DEC_CNT_W_DEF
`ifdef SPIKE_TRACE_EN
  ,
  parameter int TRACE_SHIFT = TRACE_SHIFT_DEF
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             spike,
  output logic [CNT_W-1:0] cnt,
  output logic             sat
`ifdef SPIKE_TRACE_EN
  ,
  output logic [CNT_W-1:0] trace
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;

  // Clear wins over counting; a spike arriving at full scale only marks saturation
  always_comb begin
    cnt_d = cnt_q;
    sat_d = sat_q;
    if (clr) begin
      cnt_d = '0;
      sat_d = 1'b0;
    end else if (en && spike) begin
      if (cnt_q == CNT_MAX) begin
        sat_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Counter and sticky flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sat_q <= sat_d;
    end
  end

  assign cnt = cnt_q;
  assign sat = sat_q;

`ifdef SPIKE_TRACE_EN
  localparam logic [CNT_W:0] TRACE_INC = (CNT_W+1)'(2 ** (CNT_W - 2));

  logic [CNT_W-1:0] trace_q, trace_d;
  logic [CNT_W:0]   trace_sum;

  // Leaky integration runs in every state; one extra bit catches overflow for saturation
  always_comb begin
    trace_sum = {1'b0, trace_q} - {1'b0, (trace_q >> TRACE_SHIFT)}
              + (spike ? TRACE_INC : '0);
    trace_d   = trace_sum[CNT_W] ? CNT_MAX : trace_sum[CNT_W-1:0];
  end

  // Trace register
  always_ff @(posedge clk) begin
    if (rst) begin
      trace_q <= '0;
    end else begin
      trace_q <= trace_d;
    end
  end

  assign trace = trace_q;
`endif

endmodule

// File: rtl/spike_rate_decoder.sv
// rtl/spike_rate_decoder.sv - windowed per-channel spike counting with valid/ready readout (optional trace: SPIKE_TRACE_EN)
module spike_rate_decoder
  import snn_pkg::*;
#(
  parameter int NUM_CH = DEC_NUM_CH_DEF,
  parameter int CNT_W  = DEC_CNT_W_DEF,
  parameter int WIN_W  = DEC_WIN_W_DEF
`ifdef SPIKE_TRACE_EN
  ,
  parameter int TRACE_SHIFT = TRACE_SHIFT_DEF
`endif
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       spike_in,
  input  logic [WIN_W-1:0]        window_len,
  input  logic                    start,
  output logic                    busy,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NUM_CH*CNT_W-1:0] out_counts,
  output logic [NUM_CH-1:0]       out_sat
`ifdef SPIKE_TRACE_EN
  ,
  output logic [NUM_CH*CNT_W-1:0] out_trace
`endif
);

  // Window counter is one bit wider so a zero length can stand for 2^WIN_W samples
  localparam logic [WIN_W:0] WIN_ONE = (WIN_W+1)'(1);

  dec_state_t     state_q, state_d;
  logic [WIN_W:0] win_q, win_d;
  logic           busy_q, busy_d;
  logic           valid_q, valid_d;
  logic [WIN_W:0] win_load;
  logic           cnt_clr;
  logic           cnt_en;

  assign win_load = (window_len == '0) ? {1'b1, {WIN_W{1'b0}}} : {1'b0, window_len};

  // Next-state logic: counters are cleared while idle and on the readout handshake
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_clr = 1'b1;
        if (start) begin
          state_d = COUNT;
          win_d   = win_load;
        end
      end
      COUNT: begin
        cnt_en = 1'b1;
        win_d  = win_q - WIN_ONE;
        if (win_q == WIN_ONE) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          cnt_clr = 1'b1;
          if (start) begin
            state_d = COUNT;
            win_d   = win_load;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_clr = 1'b1;
      end
    endcase
    busy_d  = (state_d != IDLE);
    valid_d = (state_d == HOLD);
  end

  // FSM state, window counter and registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      win_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
    end
  end

  assign busy      = busy_q;
  assign out_valid = valid_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    spike_counter_sat #(
      .CNT_W(CNT_W)
`ifdef SPIKE_TRACE_EN
      ,
      .TRACE_SHIFT(TRACE_SHIFT)
`endif
    ) u_cnt (
      .clk  (clk),
      .rst  (rst),
      .clr  (cnt_clr),
      .en   (cnt_en),
      .spike(spike_in[i]),
      .cnt  (out_counts[i*CNT_W +: CNT_W]),
      .sat  (out_sat[i])
`ifdef SPIKE_TRACE_EN
      ,
      .trace(out_trace[i*CNT_W +: CNT_W])
`endif
    );
  end

endmodule

// File: tb/tb_spike_rate_decoder.sv
// tb/tb_spike_rate_decoder.sv - self-checking bench for spike_rate_decoder (trace checks under SPIKE_TRACE_EN)
module tb_spike_rate_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  spike_in;
  logic [7:0]  window_len;
  logic        start;
  logic        busy;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_counts;
  logic [1:0]  out_sat;
`ifdef SPIKE_TRACE_EN
  logic [15:0] out_trace;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] exp_counts;
  logic [1:0]  exp_sat;

  always #5 clk = ~clk;

  spike_rate_decoder dut (
    .clk       (clk),
    .rst       (rst),
    .spike_in  (spike_in),
    .window_len(window_len),
    .start     (start),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_counts(out_counts),
    .out_sat   (out_sat)
`ifdef SPIKE_TRACE_EN
    ,
    .out_trace (out_trace)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int clip(input int s);
    return (s > 255) ? 255 : s;
  endfunction

  // Issue a start edge with the given window length
  task automatic begin_window(input int len_cfg);
    window_len = len_cfg[7:0];
    start      = 1'b1;
    spike_in   = $urandom;
    tick();
    start = 1'b0;
  endtask

  // Drive L sample cycles; pat 0: ch0 only, 1: ch1 alternate, 2: both, 3: random incl. ignored starts
  task automatic count_window(input int L, input int pat, input string tag);
    int s0 = 0;
    int s1 = 0;
    logic [1:0] v;
    for (int k = 1; k <= L; k++) begin
      case (pat)
        0:       v = 2'b01;
        1:       v = {k[0], 1'b0};
        2:       v = 2'b11;
        default: v = 2'($urandom);
      endcase
      spike_in = v;
      if (pat == 3) begin
        start      = 1'($urandom);
        window_len = 8'($urandom);
      end
      s0 += int'(v[0]);
      s1 += int'(v[1]);
      tick();
      if (k == L - 1) chk({tag, "_valid_early"}, 64'(out_valid), 64'(0));
    end
    start    = 1'b0;
    spike_in = $urandom;
    exp_counts = {8'(clip(s1)), 8'(clip(s0))};
    exp_sat    = {s1 > 255, s0 > 255};
    chk({tag, "_valid"}, 64'(out_valid), 64'(1));
    chk({tag, "_busy"}, 64'(busy), 64'(1));
    chk({tag, "_counts"}, 64'(out_counts), 64'(exp_counts));
    chk({tag, "_sat"}, 64'(out_sat), 64'(exp_sat));
  endtask

  task automatic finish_idle(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_idle_valid"}, 64'(out_valid), 64'(0));
    chk({tag, "_idle_busy"}, 64'(busy), 64'(0));
  endtask

  initial begin
    rst        = 1'b1;
    spike_in   = '0;
    window_len = '0;
    start      = 1'b0;
    out_ready  = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_valid", 64'(out_valid), 64'(0));
    chk("rst_counts", 64'(out_counts), 64'(0));
    chk("rst_sat", 64'(out_sat), 64'(0));

`ifdef SPIKE_TRACE_EN
    spike_in = 2'b01;
    tick();
    spike_in = 2'b00;
    chk("trace_0", 64'(out_trace[7:0]), 64'(64));
    tick();
    chk("trace_1", 64'(out_trace[7:0]), 64'(48));
    tick();
    chk("trace_2", 64'(out_trace[7:0]), 64'(36));
    tick();
    chk("trace_3", 64'(out_trace[7:0]), 64'(27));
    chk("trace_ch1", 64'(out_trace[15:8]), 64'(0));
`endif

    begin_window(10);
    count_window(10, 0, "w10");
    finish_idle("w10");

    begin_window(8);
    count_window(8, 1, "w8");
    for (int c = 0; c < 5; c++) begin
      spike_in = 2'($urandom);
      tick();
      chk("w8_hold_valid", 64'(out_valid), 64'(1));
      chk("w8_hold_counts", 64'(out_counts), 64'(exp_counts));
    end
    finish_idle("w8");

    begin_window(0);
    count_window(256, 2, "w256");

    out_ready  = 1'b1;
    start      = 1'b1;
    window_len = 8'd3;
    spike_in   = 2'b11;
    tick();
    out_ready = 1'b0;
    start     = 1'b0;
    chk("b2b_busy", 64'(busy), 64'(1));
    chk("b2b_valid", 64'(out_valid), 64'(0));
    count_window(3, 1, "b2b");
    finish_idle("b2b");

    begin_window(20);
    for (int k = 0; k < 5; k++) begin
      spike_in = 2'b11;
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_valid", 64'(out_valid), 64'(0));
    chk("abort_counts", 64'(out_counts), 64'(0));
    chk("abort_sat", 64'(out_sat), 64'(0));
    begin
      int seen = 0;
      for (int k = 0; k < 25; k++) begin
        spike_in = 2'($urandom);
        tick();
        if (out_valid !== 1'b0) seen++;
      end
      chk("abort_no_valid", 64'(seen), 64'(0));
    end

    for (int it = 0; it < 8; it++) begin
      int L;
      L = int'($urandom_range(1, 40));
      begin_window(L);
      count_window(L, 3, "rnd");
      for (int d = 0; d < int'($urandom_range(0, 3)); d++) begin
        start = 1'($urandom);
        tick();
        chk("rnd_hold_counts", 64'(out_counts), 64'(exp_counts));
      end
      start = 1'b0;
      finish_idle("rnd");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
